// File: rtl/dc_mem_responder_if.sv
// -----------------------------------------------------------------------------
// dc_mem_responder_if
// Handshake bundle between the D-cache LSU (master) and the memory-side
// responder (slave).
//
// Write channel : dcw_start_rq, dcw_in_addr[31:0], dcw_in_mask[15:0],
//                 dcw_in_data[127:0]           (master -> slave)
//                 dcw_finish_wresp             (slave -> master)
// Read channel  : dcr_start_rq, dcr_rin_addr[31:0], rqfull_1 (master -> slave)
//                 rdat_m_data[127:0], rdat_m_valid, finish_mrd (slave -> master)
// Status        : rsp_busy, rsp_ovf_err        (slave -> master)
// -----------------------------------------------------------------------------
interface dc_mem_responder_if;
    logic         dcw_start_rq;
    logic [31:0]  dcw_in_addr;
    logic [15:0]  dcw_in_mask;
    logic [127:0] dcw_in_data;
    logic         dcw_finish_wresp;

    logic         dcr_start_rq;
    logic [31:0]  dcr_rin_addr;
    logic         rqfull_1;
    logic [127:0] rdat_m_data;
    logic         rdat_m_valid;
    logic         finish_mrd;

    logic         rsp_busy;
    logic         rsp_ovf_err;

    modport master (
        output dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
        output dcr_start_rq, dcr_rin_addr, rqfull_1,
        input  dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd,
        input  rsp_busy, rsp_ovf_err
    );

    modport slave (
        input  dcw_start_rq, dcw_in_addr, dcw_in_mask, dcw_in_data,
        input  dcr_start_rq, dcr_rin_addr, rqfull_1,
        output dcw_finish_wresp, rdat_m_data, rdat_m_valid, finish_mrd,
        output rsp_busy, rsp_ovf_err
    );
endinterface

// File: rtl/dc_mem_responder.sv
// -----------------------------------------------------------------------------
// dc_mem_responder
// Memory-side responder for the D-cache LSU. Accepts 128-bit line write-backs
// (byte-masked) and line-fill reads, and serves them one at a time from an
// internal single-port line RAM after a configurable latency.
//
// Ports:
//   clk    - clock
//   rst_n  - asynchronous active-low reset (RAM contents are kept)
//   bus    - dc_mem_responder_if.slave (write/read channels and status)
//
// Parameters:
//   MWIDTH - line-index width, RAM holds 2**MWIDTH lines (index = addr[MWIDTH+3:4])
//   WR_LAT - wait cycles before a write commits (1..15)
//   RD_LAT - wait cycles before a read accesses the RAM (1..15)
//
// Optional feature (macro DCMEM_RANDLAT_EN): an 8-bit LFSR adds 0..7 random
// cycles to every latency load. Without the macro the latency is fixed.
// -----------------------------------------------------------------------------
module dc_mem_responder #(
    parameter int unsigned MWIDTH = 12,
    parameter int unsigned WR_LAT = 2,
    parameter int unsigned RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    dc_mem_responder_if.slave bus
);

    localparam int unsigned LINES = 2 ** MWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WLAT,
        S_WCMT,
        S_RLAT,
        S_RRD,
        S_RVAL
    } state_t;

    typedef logic [MWIDTH-1:0] idx_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [4:0]   r_cnt;
    logic [4:0]   w_extra;

    // One-entry pending registers per channel
    logic         r_wr_pend;
    idx_t         r_wr_idx;
    logic [15:0]  r_wr_mask;
    logic [127:0] r_wr_data;
    logic         r_rd_pend;
    idx_t         r_rd_idx;

    // Transaction currently being executed
    idx_t         r_cur_idx;
    logic [15:0]  r_cur_mask;
    logic [127:0] r_cur_data;

    logic [127:0] r_mem [LINES];
    logic [127:0] r_ram_q;
    logic [127:0] r_rdat;
    logic         r_rvalid;
    logic         r_wresp;
    logic         r_ovf;

    logic         w_take_wr;
    logic         w_take_rd;
    logic         w_lat_done;
    logic         w_accept;
    logic         w_busy;

    // Address bits outside the line index are intentionally ignored.
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^{bus.dcw_in_addr[31:MWIDTH+4], bus.dcw_in_addr[3:0],
                                  bus.dcr_rin_addr[31:MWIDTH+4], bus.dcr_rin_addr[3:0]};

    // Arbitration only in IDLE; writes win over reads.
    assign w_take_wr  = (r_state == S_IDLE) && r_wr_pend;
    assign w_take_rd  = (r_state == S_IDLE) && !r_wr_pend && r_rd_pend;
    // The counter "reaches 1" with this cycle's decrement.
    assign w_lat_done = (r_cnt <= 5'd2);
    assign w_accept   = r_rvalid && !bus.rqfull_1;

`ifdef DCMEM_RANDLAT_EN
    logic [7:0] r_lfsr;

    // Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign w_extra = {2'b00, r_lfsr[2:0]};
`else
    assign w_extra = 5'd0;
`endif

    // ---------------------------------------------------------------- FSM: state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------- FSM: next state
    // NOTE: the default assignment first keeps every path driven, so no latch
    // is inferred when a branch does not mention the signal.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_take_wr) begin
                    w_next_state = S_WLAT;
                end else if (w_take_rd) begin
                    w_next_state = S_RLAT;
                end
            end
            S_WLAT: if (w_lat_done) w_next_state = S_WCMT;
            S_WCMT: w_next_state = S_IDLE;
            S_RLAT: if (w_lat_done) w_next_state = S_RRD;
            S_RRD:  w_next_state = S_RVAL;
            S_RVAL: if (w_accept) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- FSM: outputs
    always_comb begin
        w_busy = (r_state != S_IDLE) || r_wr_pend || r_rd_pend;
    end

    assign bus.dcw_finish_wresp = r_wresp;
    assign bus.rdat_m_data      = r_rdat;
    assign bus.rdat_m_valid     = r_rvalid;
    assign bus.finish_mrd       = w_accept;
    assign bus.rsp_busy         = w_busy;
    assign bus.rsp_ovf_err      = r_ovf;

    // ---------------------------------------------------------------- request capture
    // A pulse is accepted when the entry is empty or is being consumed this
    // cycle; otherwise it is dropped and the sticky overflow flag is raised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_pend <= 1'b0;
            r_wr_idx  <= '0;
            r_wr_mask <= '0;
            r_wr_data <= '0;
            r_rd_pend <= 1'b0;
            r_rd_idx  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (bus.dcw_start_rq) begin
                if (!r_wr_pend || w_take_wr) begin
                    r_wr_pend <= 1'b1;
                    r_wr_idx  <= bus.dcw_in_addr[MWIDTH+3:4];
                    r_wr_mask <= bus.dcw_in_mask;
                    r_wr_data <= bus.dcw_in_data;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_take_wr) begin
                r_wr_pend <= 1'b0;
            end

            if (bus.dcr_start_rq) begin
                if (!r_rd_pend || w_take_rd) begin
                    r_rd_pend <= 1'b1;
                    r_rd_idx  <= bus.dcr_rin_addr[MWIDTH+3:4];
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (w_take_rd) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- transaction + counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_cur_idx  <= '0;
            r_cur_mask <= '0;
            r_cur_data <= '0;
        end else if (w_take_wr) begin
            r_cnt      <= 5'(WR_LAT) + w_extra;
            r_cur_idx  <= r_wr_idx;
            r_cur_mask <= r_wr_mask;
            r_cur_data <= r_wr_data;
        end else if (w_take_rd) begin
            r_cnt      <= 5'(RD_LAT) + w_extra;
            r_cur_idx  <= r_rd_idx;
        end else if (r_state == S_WLAT || r_state == S_RLAT) begin
            r_cnt      <= r_cnt - 5'd1;
        end
    end

    // ---------------------------------------------------------------- response registers
    // First RVAL cycle loads the beat; it is then held until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdat   <= '0;
            r_rvalid <= 1'b0;
            r_wresp  <= 1'b0;
        end else begin
            r_wresp <= (r_state == S_WCMT);
            if (r_state == S_RVAL && !r_rvalid) begin
                r_rdat   <= r_ram_q;
                r_rvalid <= 1'b1;
            end else if (w_accept) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- line RAM
    // NOTE: the RAM array and its read register have no reset so they map onto
    // block RAM; contents survive rst_n by design.
    always_ff @(posedge clk) begin
        if (r_state == S_WCMT) begin
            for (int i = 0; i < 16; i++) begin
                if (!r_cur_mask[i]) begin
                    r_mem[r_cur_idx][8*i +: 8] <= r_cur_data[8*i +: 8];
                end
            end
        end
        if (r_state == S_RRD) begin
            r_ram_q <= r_mem[r_cur_idx];
        end
    end

endmodule

// File: tb/tb_dc_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_dc_mem_responder
// Self-checking bench for dc_mem_responder (default build, fixed latency).
// A line-level memory model and the latency rules (write finish at WR_LAT+2,
// first read beat at RD_LAT+3 after the request pulse) give every expectation.
// -----------------------------------------------------------------------------
module tb_dc_mem_responder;

    localparam int MW  = 12;
    localparam int WRL = 2;
    localparam int RDL = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dc_mem_responder_if bus ();

    dc_mem_responder #(
        .MWIDTH (MW),
        .WR_LAT (WRL),
        .RD_LAT (RDL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    // Write-finish pulses seen anywhere in the run
    int n_wresp = 0;
    always @(negedge clk) if (bus.dcw_finish_wresp === 1'b1) n_wresp++;

    // Behavioural line memory
    logic [127:0] model_mem [1 << MW];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [MW-1:0] line_of(input logic [31:0] addr);
        return addr[MW+3:4];
    endfunction

    function automatic logic [127:0] merge(input logic [127:0] old, input logic [15:0] mask,
                                           input logic [127:0] data);
        logic [127:0] res;
        for (int i = 0; i < 16; i++) res[8*i +: 8] = mask[i] ? old[8*i +: 8] : data[8*i +: 8];
        return res;
    endfunction

    // Single write from an idle responder; checks finish latency and pulse width.
    task automatic do_write(input logic [31:0] addr, input logic [15:0] mask,
                            input logic [127:0] data, input string tag);
        int t0;
        int lat;
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b1;
        bus.dcw_in_addr  = addr;
        bus.dcw_in_mask  = mask;
        bus.dcw_in_data  = data;
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.dcw_finish_wresp === 1'b1) begin
                lat = cyc - t0;
                break;
            end
            @(posedge clk); #1;
            bus.dcw_start_rq = 1'b0;
        end
        check({tag, "_wlat"}, lat, WRL + 2);
        @(negedge clk);
        check({tag, "_wpulse"}, bus.dcw_finish_wresp, 1'b0);
        model_mem[line_of(addr)] = merge(model_mem[line_of(addr)], mask, data);
    endtask

    // Single read from an idle responder with bp cycles of backpressure.
    task automatic do_read(input logic [31:0] addr, input int bp,
                           input logic [127:0] exp, input string tag);
        int t0;
        int first;
        int fin_at;
        int n_val;
        int n_fin;
        logic stable;
        logic [127:0] d0;
        @(posedge clk); #1;
        bus.dcr_start_rq = 1'b1;
        bus.dcr_rin_addr = addr;
        bus.rqfull_1     = (bp > 0);
        t0 = cyc; first = -1; fin_at = -1; n_val = 0; n_fin = 0; stable = 1'b1; d0 = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.rdat_m_valid === 1'b1) begin
                if (n_val == 0) begin
                    first = cyc - t0;
                    d0    = bus.rdat_m_data;
                end else if (bus.rdat_m_data !== d0) begin
                    stable = 1'b0;
                end
                n_val++;
                if (bus.finish_mrd === 1'b1) begin
                    n_fin++;
                    fin_at = cyc - t0;
                end
            end else if (n_val > 0) begin
                break;
            end
            @(posedge clk); #1;
            bus.dcr_start_rq = 1'b0;
            if (n_val >= bp) bus.rqfull_1 = 1'b0;
        end
        bus.rqfull_1 = 1'b0;
        check({tag, "_rlat"},   first,  RDL + 3);
        check({tag, "_rdata"},  d0,     exp);
        check({tag, "_nvalid"}, n_val,  bp + 1);
        check({tag, "_nfin"},   n_fin,  1);
        check({tag, "_finat"},  fin_at, RDL + 3 + bp);
        check({tag, "_stable"}, stable, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0]  pool [8];
        logic [127:0]   wd;
        logic [127:0]   rd_seen;
        logic [31:0]    a;
        logic [15:0]    m;
        int             t0;
        int             wfin;
        int             rfirst;
        int             n0;
        int             n_val;

        bus.dcw_start_rq = 1'b0;
        bus.dcw_in_addr  = '0;
        bus.dcw_in_mask  = '0;
        bus.dcw_in_data  = '0;
        bus.dcr_start_rq = 1'b0;
        bus.dcr_rin_addr = '0;
        bus.rqfull_1     = 1'b0;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", bus.rdat_m_valid, 1'b0);
        check("rst_fin",   bus.finish_mrd, 1'b0);
        check("rst_wresp", bus.dcw_finish_wresp, 1'b0);
        check("rst_busy",  bus.rsp_busy, 1'b0);
        check("rst_ovf",   bus.rsp_ovf_err, 1'b0);
        check("rst_rdat",  bus.rdat_m_data, 128'h0);
        rst_n = 1'b1;

        // ---- full-line write then read back
        do_write(32'h0000_0120, 16'h0000, 128'h0123456789ABCDEF0123456789ABCDEF, "full");
        do_read(32'h0000_0120, 0, 128'h0123456789ABCDEF0123456789ABCDEF, "full");

        // ---- masked write over an all-ones line
        do_write(32'h0000_0200, 16'h0000, {128{1'b1}}, "ones");
        do_write(32'h0000_0200, 16'hFFFE, 128'h0011223344556677_8899AABBCCDDEE5A, "mask");
        do_read(32'h0000_0200, 0, 128'hFFFFFFFFFFFFFFFF_FFFFFFFFFFFFFF5A, "mask");

        // ---- read backpressure, 5 cycles
        do_read(32'h0000_0120, 5, 128'h0123456789ABCDEF0123456789ABCDEF, "bp5");

        // ---- address wrap: top line reached through high bits
        do_write(32'hFFFF_FFF0, 16'h0000, 128'hCAFEF00DCAFEF00D_1234567812345678, "wrapw");
        do_read(32'h0000_FFF7, 0, 128'hCAFEF00DCAFEF00D_1234567812345678, "wrapr");

        // ---- simultaneous write+read to line 0x33 (line pre-filled with old data)
        do_write(32'h0000_0330, 16'h0000, 128'h1, "pre33");
        wd = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b1; bus.dcw_in_addr = 32'h0000_0330;
        bus.dcw_in_mask  = '0;   bus.dcw_in_data = wd;
        bus.dcr_start_rq = 1'b1; bus.dcr_rin_addr = 32'h0000_0330;
        t0 = cyc; wfin = -1; rfirst = -1; rd_seen = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.dcw_finish_wresp === 1'b1 && wfin < 0) wfin = cyc - t0;
            if (bus.rdat_m_valid === 1'b1 && rfirst < 0) begin
                rfirst  = cyc - t0;
                rd_seen = bus.rdat_m_data;
            end
            if (bus.finish_mrd === 1'b1) break;
            @(posedge clk); #1;
            bus.dcw_start_rq = 1'b0;
            bus.dcr_start_rq = 1'b0;
        end
        // Read starts from IDLE in the write-finish cycle: as if pulsed one cycle earlier.
        check("sim_wfin",   wfin,   WRL + 2);
        check("sim_rfirst", rfirst, (WRL + 2 - 1) + RDL + 3);
        check("sim_rdata",  rd_seen, wd);
        model_mem[8'h33] = wd;
        @(negedge clk);

        // ---- overflow: A pending+consumed, B accepted during WLAT, C dropped
        do_write(32'h0000_0420, 16'h0000, 128'hC0C0, "prec");
        n0 = n_wresp;
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b1; bus.dcw_in_addr = 32'h0000_0400;
        bus.dcw_in_mask  = '0;   bus.dcw_in_data = 128'hAAAA;
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b0;
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b1; bus.dcw_in_addr = 32'h0000_0410; bus.dcw_in_data = 128'hBBBB;
        @(negedge clk);
        check("ovf_before", bus.rsp_ovf_err, 1'b0);
        @(posedge clk); #1;
        bus.dcw_in_addr = 32'h0000_0420; bus.dcw_in_data = 128'hDEAD;
        @(negedge clk);
        check("ovf_b_ok", bus.rsp_ovf_err, 1'b0);
        @(posedge clk); #1;
        bus.dcw_start_rq = 1'b0;
        @(negedge clk);
        check("ovf_set", bus.rsp_ovf_err, 1'b1);
        repeat (20) @(posedge clk);
        check("ovf_nfin", n_wresp - n0, 2);
        model_mem[8'h40] = 128'hAAAA;
        model_mem[8'h41] = 128'hBBBB;
        do_read(32'h0000_0420, 0, 128'hC0C0, "ovf_c");
        do_read(32'h0000_0410, 0, 128'hBBBB, "ovf_b");
        check("ovf_sticky", bus.rsp_ovf_err, 1'b1);

        // ---- reset during RLAT
        @(posedge clk); #1;
        bus.dcr_start_rq = 1'b1; bus.dcr_rin_addr = 32'h0000_0400;
        @(posedge clk); #1;
        bus.dcr_start_rq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rlat_busy", bus.rsp_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", bus.rdat_m_valid, 1'b0);
        check("mrst_busy",  bus.rsp_busy, 1'b0);
        check("mrst_ovf",   bus.rsp_ovf_err, 1'b0);
        check("mrst_rdat",  bus.rdat_m_data, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_val = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.rdat_m_valid !== 1'b0) n_val++;
        end
        check("mrst_novalid", n_val, 0);
        do_read(32'h0000_0400, 0, 128'hAAAA, "post_rst");

        // ---- randomized traffic over a pool of lines
        for (int i = 0; i < 8; i++) begin
            pool[i] = MW'(16'h0100 + i * 37);
            a = $urandom;
            a[MW+3:4] = pool[i];
            do_write(a, 16'h0000, {$urandom, $urandom, $urandom, $urandom}, "rinit");
        end
        for (int i = 0; i < 24; i++) begin
            logic [MW-1:0] ln;
            ln = pool[$urandom_range(0, 7)];
            a  = $urandom;
            a[MW+3:4] = ln;
            if ($urandom_range(0, 1) == 1) begin
                m = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
                do_write(a, m, {$urandom, $urandom, $urandom, $urandom}, "rw");
            end else begin
                do_read(a, $urandom_range(0, 3), model_mem[ln], "rr");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
